issue_scoreboard: RTL

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/issue_scoreboard.sv | 115 +++++++++++
 1 files changed

// File: rtl/issue_scoreboard.sv
// In-order issue stage with a per-warp register busy table (RAW/WAW interlock),
// a one-entry output register, a stall performance counter and a deadlock watchdog.
module issue_scoreboard #(
  parameter int NUM_WARPS     = 4,
  parameter int NR_BITS       = 6,
  parameter int DATAW         = 128,
  parameter int STALL_TIMEOUT = 1023,
  localparam int WIDW         = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ib_valid,
  output logic               ib_ready,
  input  logic [WIDW-1:0]    ib_wid,
  input  logic               ib_wb,
  input  logic [NR_BITS-1:0] ib_rd,
  input  logic [NR_BITS-1:0] ib_rs1,
  input  logic [NR_BITS-1:0] ib_rs2,
  input  logic [NR_BITS-1:0] ib_rs3,
  input  logic [DATAW-1:0]   ib_data,
  output logic               is_valid,
  input  logic               is_ready,
  output logic [WIDW-1:0]    is_wid,
  output logic [DATAW-1:0]   is_data,
  input  logic               wb_valid,
  input  logic [WIDW-1:0]    wb_wid,
  input  logic [NR_BITS-1:0] wb_rd,
  input  logic               wb_eop,
  output logic [31:0]        stall_cycles,
  output logic               deadlock
);

  localparam int NUM_REGS = 1 << NR_BITS;
  localparam int WDW      = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(STALL_TIMEOUT);

  logic [NUM_REGS-1:0] busy_q [NUM_WARPS];
  logic [NUM_REGS-1:0] busy_d [NUM_WARPS];
  logic [NUM_REGS-1:0] eff    [NUM_WARPS];

  logic               is_valid_q, is_valid_d;
  logic [WIDW-1:0]    is_wid_q, is_wid_d;
  logic [DATAW-1:0]   is_data_q, is_data_d;
  logic [31:0]        stall_q, stall_d;
  logic [WDW-1:0]     wd_q, wd_d;
  logic               deadlock_q, deadlock_d;

  logic hazard;
  logic ready;
  logic fire;

  always_comb begin
    // Release bypass: a retiring writeback unblocks a waiting reader in the same cycle.
    eff = busy_q;
    if (wb_valid && wb_eop) eff[wb_wid][wb_rd] = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) eff[w][0] = 1'b0;

    hazard = ib_valid && (eff[ib_wid][ib_rs1] || eff[ib_wid][ib_rs2] ||
                          eff[ib_wid][ib_rs3] || (ib_wb && eff[ib_wid][ib_rd]));
    ready  = !hazard && (!is_valid_q || is_ready);
    fire   = ib_valid && ready;

    // Set is applied after the release so a same-entry set wins.
    busy_d = eff;
    if (fire && ib_wb && (ib_rd != '0)) busy_d[ib_wid][ib_rd] = 1'b1;

    is_valid_d = is_valid_q;
    is_wid_d   = is_wid_q;
    is_data_d  = is_data_q;
    if (fire) begin
      is_valid_d = 1'b1;
      is_wid_d   = ib_wid;
      is_data_d  = ib_data;
    end else if (is_ready) begin
      is_valid_d = 1'b0;
    end

    stall_d = stall_q + {31'b0, hazard};

    wd_d = wd_q;
    if (!ib_valid || fire)  wd_d = '0;
    else if (wd_q != WD_LIMIT) wd_d = wd_q + WDW'(1);
    deadlock_d = deadlock_q || (wd_d == WD_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) busy_q[w] <= '0;
      is_valid_q <= 1'b0;
      stall_q    <= '0;
      wd_q       <= '0;
      deadlock_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      is_valid_q <= is_valid_d;
      stall_q    <= stall_d;
      wd_q       <= wd_d;
      deadlock_q <= deadlock_d;
    end
  end

  // Payload register carries no reset; it is only meaningful while is_valid is high.
  always_ff @(posedge clk) begin
    is_wid_q  <= is_wid_d;
    is_data_q <= is_data_d;
  end

  assign ib_ready     = ready;
  assign is_valid     = is_valid_q;
  assign is_wid       = is_wid_q;
  assign is_data      = is_data_q;
  assign stall_cycles = stall_q;
  assign deadlock     = deadlock_q;

endmodule
